snitch_icache_refill_writer: RTL and testbench

Refill-side counterpart of the L1 lookup stage. It accepts a miss request and collects the refill beats from the L2/AXI side into a full cache line. It picks a victim way and drives the lookup's RAM write port (write_addr/set/data/tag/error) with a valid/ready handshake. Once the line has been written, it returns the line to the miss handler so a later lookup of the same address hits.

---
 rtl/snitch_icache_pkg.sv | 20 ++
 rtl/snitch_icache_refill_writer_if.sv | 63 ++++++
 rtl/snitch_icache_refill_writer.sv | 133 +++++++++++++
 tb/tb_snitch_icache_refill_writer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared types and helpers for the instruction-cache refill path.
package snitch_icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    RESPOND
  } refill_state_e;

  function automatic int unsigned beats_per_line(input int unsigned line_w,
                                                 input int unsigned beat_w);
    return line_w / beat_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snitch_icache_refill_writer_if.sv
// Miss, refill-beat, RAM-write and completion channels of the refill writer.
interface snitch_icache_refill_writer_if #(
  parameter int unsigned FETCH_AW    = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned BEAT_WIDTH  = 32,
  parameter int unsigned WAY_COUNT   = 4,
  parameter int unsigned LINE_ALIGN  = 4,
  parameter int unsigned COUNT_ALIGN = 5,
  parameter int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
  parameter int unsigned SET_ALIGN   = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
);

  logic [FETCH_AW-1:0]    miss_addr_i;
  logic [ID_WIDTH-1:0]    miss_id_i;
  logic                   miss_valid_i;
  logic                   miss_ready_o;

  logic [BEAT_WIDTH-1:0]  refill_data_i;
  logic                   refill_error_i;
  logic                   refill_last_i;
  logic                   refill_valid_i;
  logic                   refill_ready_o;

  logic [COUNT_ALIGN-1:0] write_addr_o;
  logic [SET_ALIGN-1:0]   write_set_o;
  logic [LINE_WIDTH-1:0]  write_data_o;
  logic [TAG_WIDTH-1:0]   write_tag_o;
  logic                   write_error_o;
  logic                   write_valid_o;
  logic                   write_ready_i;

  logic [ID_WIDTH-1:0]    rsp_id_o;
  logic [LINE_WIDTH-1:0]  rsp_data_o;
  logic                   rsp_error_o;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;

  modport slave (
    input  miss_addr_i, miss_id_i, miss_valid_i,
    output miss_ready_o,
    input  refill_data_i, refill_error_i, refill_last_i, refill_valid_i,
    output refill_ready_o,
    output write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o,
    output write_valid_o,
    input  write_ready_i,
    output rsp_id_o, rsp_data_o, rsp_error_o, rsp_valid_o,
    input  rsp_ready_i
  );

  modport master (
    output miss_addr_i, miss_id_i, miss_valid_i,
    input  miss_ready_o,
    output refill_data_i, refill_error_i, refill_last_i, refill_valid_i,
    input  refill_ready_o,
    input  write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o,
    input  write_valid_o,
    output write_ready_i,
    input  rsp_id_o, rsp_data_o, rsp_error_o, rsp_valid_o,
    output rsp_ready_i
  );

endinterface

// File: rtl/snitch_icache_refill_writer.sv
// Assembles refill beats into a cache line, writes it into a round-robin victim
// way of the lookup RAM, then reports the completed line to the miss handler.
module snitch_icache_refill_writer
  import snitch_icache_pkg::*;
#(
  parameter int unsigned FETCH_AW    = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned BEAT_WIDTH  = 32,
  parameter int unsigned WAY_COUNT   = 4,
  parameter int unsigned LINE_ALIGN  = 4,
  parameter int unsigned COUNT_ALIGN = 5,
  parameter int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
  parameter int unsigned SET_ALIGN   = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
) (
  input logic clk_i,
  input logic rst_i,
  snitch_icache_refill_writer_if.slave bus
);

  localparam int unsigned BEATS = beats_per_line(LINE_WIDTH, BEAT_WIDTH);
  localparam int unsigned CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [SET_ALIGN-1:0] LAST_WAY  = SET_ALIGN'(WAY_COUNT - 1);

  refill_state_e          state_q;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   err_q;
  logic [SET_ALIGN-1:0]   victim_q;
  logic [LINE_WIDTH-1:0]  line_q;
  logic [COUNT_ALIGN-1:0] index_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic                   miss_ready_q;
  logic                   refill_ready_q;
  logic                   write_valid_q;
  logic                   rsp_valid_q;

  logic beat_hs;
  logic beat_final;
  logic unused_offset;

  // Byte offset within the line never reaches the RAM.
  assign unused_offset = ^bus.miss_addr_i[LINE_ALIGN-1:0];

  assign beat_hs    = bus.refill_valid_i & refill_ready_q;
  assign beat_final = (beat_cnt == LAST_BEAT) | bus.refill_last_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      beat_cnt       <= '0;
      err_q          <= 1'b0;
      victim_q       <= '0;
      line_q         <= '0;
      miss_ready_q   <= 1'b1;
      refill_ready_q <= 1'b0;
      write_valid_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.miss_valid_i && miss_ready_q) begin
            index_q        <= bus.miss_addr_i[LINE_ALIGN +: COUNT_ALIGN];
            tag_q          <= bus.miss_addr_i[FETCH_AW-1 : LINE_ALIGN+COUNT_ALIGN];
            id_q           <= bus.miss_id_i;
            beat_cnt       <= '0;
            err_q          <= 1'b0;
            line_q         <= '0;
            miss_ready_q   <= 1'b0;
            refill_ready_q <= 1'b1;
            state_q        <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_hs) begin
            for (int b = 0; b < BEATS; b++) begin
              if (beat_cnt == CNT_W'(b)) begin
                line_q[b*BEAT_WIDTH +: BEAT_WIDTH] <= bus.refill_data_i;
              end
            end
            beat_cnt <= beat_cnt + 1'b1;
            // A last flag that disagrees with the beat count (early or missing)
            // marks the line as unusable.
            err_q <= err_q | bus.refill_error_i
                   | ((beat_cnt == LAST_BEAT) != bus.refill_last_i);
            if (beat_final) begin
              refill_ready_q <= 1'b0;
              write_valid_q  <= 1'b1;
              state_q        <= WRITE;
            end
          end
        end
        WRITE: begin
          if (bus.write_ready_i) begin
            victim_q      <= (victim_q == LAST_WAY) ? '0 : victim_q + 1'b1;
            write_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESPOND;
          end
        end
        RESPOND: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
            miss_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.miss_ready_o   = miss_ready_q;
  assign bus.refill_ready_o = refill_ready_q;
  assign bus.write_addr_o   = index_q;
  assign bus.write_set_o    = victim_q;
  assign bus.write_data_o   = line_q;
  assign bus.write_tag_o    = tag_q;
  assign bus.write_error_o  = err_q;
  assign bus.write_valid_o  = write_valid_q;
  assign bus.rsp_id_o       = id_q;
  assign bus.rsp_data_o     = line_q;
  assign bus.rsp_error_o    = err_q;
  assign bus.rsp_valid_o    = rsp_valid_q;

  // A final beat arriving without its last flag must still end the collection
  // and poison the line.
  missing_last_poisons: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == COLLECT && beat_hs && beat_cnt == LAST_BEAT && !bus.refill_last_i)
    |=> (state_q == WRITE && err_q));

endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// Directed and randomized refill transactions against a line-level reference model.
module tb_snitch_icache_refill_writer;

  localparam int FETCH_AW    = 32;
  localparam int ID_WIDTH    = 4;
  localparam int LINE_WIDTH  = 128;
  localparam int BEAT_WIDTH  = 32;
  localparam int WAY_COUNT   = 4;
  localparam int LINE_ALIGN  = 4;
  localparam int COUNT_ALIGN = 5;
  localparam int TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;
  localparam int SET_ALIGN   = 2;
  localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int BOUND       = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snitch_icache_refill_writer_if #(
    .FETCH_AW(FETCH_AW), .ID_WIDTH(ID_WIDTH), .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH), .WAY_COUNT(WAY_COUNT), .LINE_ALIGN(LINE_ALIGN),
    .COUNT_ALIGN(COUNT_ALIGN)
  ) bus ();

  snitch_icache_refill_writer #(
    .FETCH_AW(FETCH_AW), .ID_WIDTH(ID_WIDTH), .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH), .WAY_COUNT(WAY_COUNT), .LINE_ALIGN(LINE_ALIGN),
    .COUNT_ALIGN(COUNT_ALIGN)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_victim = 0;

  task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs,
                       input logic [LINE_WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_miss(input logic [FETCH_AW-1:0] addr, input logic [ID_WIDTH-1:0] id);
    int t = 0;
    bus.miss_addr_i  = addr;
    bus.miss_id_i    = id;
    bus.miss_valid_i = 1'b1;
    while (bus.miss_ready_o !== 1'b1 && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check("miss_hs_in_time", t < BOUND, 1);
    @(negedge clk);
    bus.miss_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [BEAT_WIDTH-1:0] d, input logic e, input logic l);
    int t = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    bus.refill_data_i  = d;
    bus.refill_error_i = e;
    bus.refill_last_i  = l;
    bus.refill_valid_i = 1'b1;
    while (bus.refill_ready_o !== 1'b1 && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check("beat_hs_in_time", t < BOUND, 1);
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    bus.refill_error_i = 1'b0;
    bus.refill_last_i  = 1'b0;
  endtask

  // last_idx: beat carrying the last flag, -1 for none. err_mask bit i flags beat i.
  task automatic run_txn(input logic [FETCH_AW-1:0] addr, input logic [ID_WIDTH-1:0] id,
                         input int last_idx, input int err_mask,
                         input int wstall, input int rstall,
                         input bit use_seed, input logic [LINE_WIDTH-1:0] seed);
    int k;
    logic [LINE_WIDTH-1:0] exp_line = '0;
    logic exp_err = 1'b0;
    logic [BEAT_WIDTH-1:0] d;
    int exp_idx, exp_tag, exp_set;

    k = (last_idx >= 0 && last_idx < BEATS) ? last_idx + 1 : BEATS;
    exp_idx = int'((addr >> LINE_ALIGN) % (1 << COUNT_ALIGN));
    exp_tag = int'(addr >> (LINE_ALIGN + COUNT_ALIGN));
    exp_set = model_victim;
    exp_err = (last_idx != BEATS - 1);

    do_miss(addr, id);
    check("refill_ready_after_miss", bus.refill_ready_o, 1);
    check("miss_ready_low_collect", bus.miss_ready_o, 0);
    for (int i = 0; i < k; i++) begin
      d = use_seed ? seed[i*BEAT_WIDTH +: BEAT_WIDTH] : BEAT_WIDTH'($urandom);
      exp_line[i*BEAT_WIDTH +: BEAT_WIDTH] = d;
      if (err_mask[i]) exp_err = 1'b1;
      send_beat(d, err_mask[i], i == last_idx);
    end

    check("write_valid_1cyc", bus.write_valid_o, 1);
    bus.write_ready_i = 1'b0;
    for (int s = 0; s <= wstall; s++) begin
      check("write_addr", bus.write_addr_o, exp_idx);
      check("write_tag",  bus.write_tag_o,  exp_tag);
      check("write_set",  bus.write_set_o,  exp_set);
      check("write_data", bus.write_data_o, exp_line);
      check("write_err",  bus.write_error_o, exp_err);
      if (s < wstall) begin
        check("wstall_valid",        bus.write_valid_o,  1);
        check("wstall_refill_ready", bus.refill_ready_o, 0);
        check("wstall_miss_ready",   bus.miss_ready_o,   0);
        check("wstall_rsp_valid",    bus.rsp_valid_o,    0);
        @(negedge clk);
      end
    end
    bus.write_ready_i = 1'b1;
    @(negedge clk);
    bus.write_ready_i = 1'b0;
    model_victim = (model_victim + 1) % WAY_COUNT;
    check("write_valid_drop", bus.write_valid_o, 0);
    check("rsp_valid_1cyc",   bus.rsp_valid_o,   1);

    bus.rsp_ready_i = 1'b0;
    for (int s = 0; s <= rstall; s++) begin
      check("rsp_id",    bus.rsp_id_o,    id);
      check("rsp_data",  bus.rsp_data_o,  exp_line);
      check("rsp_err",   bus.rsp_error_o, exp_err);
      check("rsp_valid", bus.rsp_valid_o, 1);
      if (s < rstall) @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("rsp_valid_drop",   bus.rsp_valid_o,  0);
    check("miss_ready_again", bus.miss_ready_o, 1);
  endtask

  initial begin
    logic [LINE_WIDTH-1:0] seed1;
    int r, lidx, emask;
    seed1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    bus.miss_addr_i = '0; bus.miss_id_i = '0; bus.miss_valid_i = 1'b0;
    bus.refill_data_i = '0; bus.refill_error_i = 1'b0; bus.refill_last_i = 1'b0;
    bus.refill_valid_i = 1'b0; bus.write_ready_i = 1'b0; bus.rsp_ready_i = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_miss_ready",   bus.miss_ready_o,   1);
    check("rst_refill_ready", bus.refill_ready_o, 0);
    check("rst_write_valid",  bus.write_valid_o,  0);
    check("rst_rsp_valid",    bus.rsp_valid_o,    0);
    check("rst_write_set",    bus.write_set_o,    0);

    // Directed line at 0x1230, then four more back-to-back: ways 0,1,2,3,0.
    run_txn(32'h0000_1230, 4'h5, BEATS - 1, 0, 0, 0, 1'b1, seed1);
    for (int n = 0; n < 4; n++)
      run_txn($urandom, ID_WIDTH'($urandom), BEATS - 1, 0, 0, 0, 1'b0, '0);

    // Bus error on the second beat only.
    run_txn($urandom, 4'h3, BEATS - 1, 32'b0010, 1, 1, 1'b0, '0);
    // Last flag on the second beat.
    run_txn($urandom, 4'h7, 1, 0, 0, 0, 1'b0, '0);
    // Write held off for a full flush sweep.
    run_txn($urandom, 4'hA, BEATS - 1, 0, 33, 2, 1'b0, '0);
    // Final beat without last flag.
    run_txn($urandom, 4'hC, -1, 0, 0, 0, 1'b0, '0);

    for (int n = 0; n < 8; n++) begin
      r = $urandom_range(0, 5);
      lidx = (r == 5) ? -1 : ((r == 4) ? BEATS - 1 : r);
      emask = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
      run_txn($urandom, ID_WIDTH'($urandom), lidx, emask,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, '0);
    end

    // Reset in the middle of a collection discards it and restarts the victim.
    do_miss(32'h0000_4560, 4'h9);
    send_beat(32'hDEADBEEF, 1'b0, 1'b0);
    send_beat(32'hCAFEF00D, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_victim = 0;
    check("midrst_miss_ready",   bus.miss_ready_o,   1);
    check("midrst_refill_ready", bus.refill_ready_o, 0);
    check("midrst_write_valid",  bus.write_valid_o,  0);
    check("midrst_rsp_valid",    bus.rsp_valid_o,    0);
    repeat (3) @(negedge clk);
    check("midrst_no_write", bus.write_valid_o, 0);
    check("midrst_no_rsp",   bus.rsp_valid_o,   0);
    run_txn(32'h0000_1230, 4'h1, BEATS - 1, 0, 0, 0, 1'b1, seed1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
